// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes, debounces and auto-repeats raw push-buttons.
// Every key channel is an independent copy of the same logic.
module key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic              ADC_CLK_10,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] PRESSED,
  output logic [N_KEYS-1:0] PRESS_PULSE,
  output logic [N_KEYS-1:0] RELEASE_PULSE,
  output logic [N_KEYS-1:0] REPEAT_PULSE
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic           sync1_q;
    logic           sync2_q;
    logic           stable_q;
    logic           stable_d;
    logic [DBW-1:0] dbc_q;
    logic [DBW-1:0] dbc_d;
    logic           acc_press;
    logic           acc_rel;
    logic           pressed_q;
    logic           press_q;
    logic           rel_q;
    logic           rpt_q;
    rpt_state_e     st_q;
    logic [RW-1:0]  rc_q;

    // Two-flop synchronizer; idles at released (1).
    always_ff @(posedge ADC_CLK_10) begin
      if (reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= KEY[k];
        sync2_q <= sync1_q;
      end
    end

    // Count consecutive mismatches; accept the new level on the last one.
    always_comb begin
      stable_d  = stable_q;
      dbc_d     = '0;
      acc_press = 1'b0;
      acc_rel   = 1'b0;
      if (sync2_q != stable_q) begin
        if (dbc_q == DB_LAST) begin
          stable_d  = sync2_q;
          acc_press = ~sync2_q;
          acc_rel   = sync2_q;
        end else begin
          dbc_d = dbc_q + DBW'(1);
        end
      end
    end

    // Debounce state plus level/edge outputs registered off the next state.
    always_ff @(posedge ADC_CLK_10) begin
      if (reset) begin
        stable_q  <= 1'b1;
        dbc_q     <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        rel_q     <= 1'b0;
      end else begin
        stable_q  <= stable_d;
        dbc_q     <= dbc_d;
        pressed_q <= ~stable_d;
        press_q   <= acc_press;
        rel_q     <= acc_rel;
      end
    end

    // Auto-repeat FSM; an accepted release overrides any due strobe.
    always_ff @(posedge ADC_CLK_10) begin
      if (reset) begin
        st_q  <= IDLE;
        rc_q  <= '0;
        rpt_q <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (acc_rel) begin
          st_q <= IDLE;
          rc_q <= '0;
        end else begin
          unique case (st_q)
            IDLE: begin
              rc_q <= '0;
              if (acc_press) st_q <= DELAY;
            end
            DELAY: begin
              if (rc_q == RD_LAST) begin
                rpt_q <= 1'b1;
                rc_q  <= '0;
                st_q  <= REPEAT;
              end else begin
                rc_q <= rc_q + RW'(1);
              end
            end
            REPEAT: begin
              if (rc_q == RP_LAST) begin
                rpt_q <= 1'b1;
                rc_q  <= '0;
              end else begin
                rc_q <= rc_q + RW'(1);
              end
            end
            default: begin
              st_q <= IDLE;
              rc_q <= '0;
            end
          endcase
        end
      end
    end

    assign PRESSED[k]       = pressed_q;
    assign PRESS_PULSE[k]   = press_q;
    assign RELEASE_PULSE[k] = rel_q;
    assign REPEAT_PULSE[k]  = rpt_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed key sequences with an event scoreboard.
// Expected strobes are queued with their cycle; a monitor pops and compares.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] KEY;
  logic [1:0] PRESSED;
  logic [1:0] PRESS_PULSE;
  logic [1:0] RELEASE_PULSE;
  logic [1:0] REPEAT_PULSE;

  key_conditioner #(
    .N_KEYS         (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .ADC_CLK_10   (clk),
    .reset        (reset),
    .KEY          (KEY),
    .PRESSED      (PRESSED),
    .PRESS_PULSE  (PRESS_PULSE),
    .RELEASE_PULSE(RELEASE_PULSE),
    .REPEAT_PULSE (REPEAT_PULSE)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } ev_t;

  ev_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  // {PRESSED, PRESS_PULSE, RELEASE_PULSE, REPEAT_PULSE}
  logic [7:0] outs;
  assign outs = {PRESSED, PRESS_PULSE, RELEASE_PULSE, REPEAT_PULSE};

  localparam logic [7:0] P0   = 8'b01_01_00_00;
  localparam logic [7:0] R0   = 8'b00_00_01_00;
  localparam logic [7:0] RP0  = 8'b01_00_00_01;
  localparam logic [7:0] P1   = 8'b10_10_00_00;
  localparam logic [7:0] R1   = 8'b00_00_10_00;

  function automatic void push(int c, logic [7:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    sb.push_back(e);
  endfunction

  task automatic at(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check(string nm, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b need %b (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: every strobe the DUT shows must be the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if ((PRESS_PULSE | RELEASE_PULSE | REPEAT_PULSE) != 2'b00) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got cyc %0d vec %b, need none",
                 cyc, outs);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.v !== outs) begin
          n_fail++;
          $display("FAIL strobe: got cyc %0d vec %b, need cyc %0d vec %b",
                   cyc, outs, e.cyc, e.v);
        end
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout, need finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    reset = 1'b1;
    KEY   = 2'b11;

    // reset state
    at(3);
    check("reset_outs", outs, 8'h00);
    reset = 1'b0;
    at(23);
    check("idle_outs", outs, 8'h00);

    // clean press / release on key 0
    t = 25;
    at(t);
    KEY[0] = 1'b0;
    push(t + 6, P0);
    at(t + 7);
    check("pressed_held", outs, 8'b01_00_00_00);
    at(t + 8);
    KEY[0] = 1'b1;
    push(t + 14, R0);
    at(t + 17);
    check("pressed_clear", outs, 8'h00);

    // bounce rejection on key 1, then a real press
    t = 50;
    at(t);      KEY[1] = 1'b0;
    at(t + 3);  KEY[1] = 1'b1;
    at(t + 6);  KEY[1] = 1'b0;
    at(t + 9);  KEY[1] = 1'b1;
    at(t + 11);
    check("bounce_none", outs, 8'h00);
    at(t + 12); KEY[1] = 1'b0;
    push(t + 18, P1);
    at(t + 20); KEY[1] = 1'b1;
    push(t + 26, R1);

    // auto-repeat on key 0: 11 strobes, release stops them
    t = 90;
    at(t);
    KEY[0] = 1'b0;
    push(t + 6, P0);
    for (int i = 0; i < 11; i++) push(t + 16 + 3 * i, RP0);
    at(t + 41);
    KEY[0] = 1'b1;
    push(t + 47, R0);

    // release accepted exactly when a repeat is due
    t = 160;
    at(t);
    KEY[0] = 1'b0;
    push(t + 6, P0);
    push(t + 16, RP0);
    push(t + 19, RP0);
    at(t + 16);
    KEY[0] = 1'b1;
    push(t + 22, R0);

    // reset while held in REPEAT, then re-accept
    t = 200;
    at(t);
    KEY[0] = 1'b0;
    push(t + 6, P0);
    push(t + 16, RP0);
    push(t + 19, RP0);
    at(t + 20);
    reset = 1'b1;
    at(t + 21);
    reset = 1'b0;
    check("midhold_reset", outs, 8'h00);
    push(t + 27, P0);
    push(t + 37, RP0);
    push(t + 40, RP0);
    push(t + 43, RP0);
    at(t + 38);
    KEY[0] = 1'b1;
    push(t + 44, R0);

    at(t + 60);
    check("final_outs", outs, 8'h00);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missed_events: got %0d pending, need 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
